multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I datapath. Steps each instruction through the

---
 rtl/multicycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Purpose  : multi-cycle RV32I sequencer (ADDI/BNE/LW/SW) sharing one memory port for fetch and data.
// Latency  : zero-wait memory: BNE 3, ADDI 4, SW 4, LW 5 cycles; each mem_ready=0 cycle adds one.
// Backpress: mem_req/mem_we/AdrSrc held until mem_ready; the sequencer stalls in FETCH/MEM meanwhile.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   opcode, funct3      instruction fields from IR, valid from DECODE onward
//   EQ                  ALU equal flag, used by BNE in EXEC
//   mem_ready           memory completes the outstanding request this cycle
//   mem_req/mem_we/AdrSrc   unified memory port request, write enable, address select
//   IRWrite, PCWrite, PCSrc, ALUctrl, ALUsrc, Immsrc, RegWrite, ResultSrc   datapath controls
//   illegal             sticky trap indication (held until rst)
//   retired             completed-instruction counter, wraps silently
module multicycle_ctrl #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 EQ,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 AdrSrc,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 PCSrc,
   output logic [1:0]           ALUctrl,
   output logic                 ALUsrc,
   output logic [1:0]           Immsrc,
   output logic                 RegWrite,
   output logic                 ResultSrc,
   output logic                 illegal,
   output logic [CNT_WIDTH-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   // Instruction class captured in DECODE so later states do not depend on IR timing.
   typedef enum logic [1:0] {
      K_ADDI, K_BNE, K_LW, K_SW
   } kind_t;

   state_t state, state_nx;
   kind_t  kind, kind_nx;
   logic   retire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_FETCH;
         kind    <= K_ADDI;
         retired <= '0;
      end else begin
         state <= state_nx;
         kind  <= kind_nx;
         if (retire)
            retired <= retired + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      state_nx  = state;
      kind_nx   = kind;
      retire    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      ALUctrl   = 2'b00;
      ALUsrc    = 1'b0;
      Immsrc    = 2'b00;
      RegWrite  = 1'b0;
      ResultSrc = 1'b0;
      illegal   = 1'b0;

      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               IRWrite  = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            // An X in the encoding matches no item and falls to the trap.
            state_nx = S_EXEC;
            case ({opcode, funct3})
               10'b0010011_000: kind_nx = K_ADDI;
               10'b1100011_001: kind_nx = K_BNE;
               10'b0000011_010: kind_nx = K_LW;
               10'b0100011_010: kind_nx = K_SW;
               default:         state_nx = S_TRAP;
            endcase
         end
         S_EXEC: begin
            case (kind)
               K_ADDI: begin
                  ALUsrc   = 1'b1;
                  state_nx = S_WB;
               end
               K_LW: begin
                  ALUsrc   = 1'b1;
                  state_nx = S_MEM;
               end
               K_SW: begin
                  ALUsrc   = 1'b1;
                  Immsrc   = 2'b10;
                  state_nx = S_MEM;
               end
               default: begin
                  // BNE resolves and retires here: taken when the operands differ.
                  Immsrc   = 2'b01;
                  ALUctrl  = 2'b01;
                  PCWrite  = 1'b1;
                  PCSrc    = ~EQ;
                  retire   = 1'b1;
                  state_nx = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
            mem_we  = (kind == K_SW);
            if (mem_ready) begin
               if (kind == K_SW) begin
                  PCWrite  = 1'b1;
                  retire   = 1'b1;
                  state_nx = S_FETCH;
               end else begin
                  state_nx = S_WB;
               end
            end
         end
         S_WB: begin
            RegWrite  = 1'b1;
            ResultSrc = (kind == K_LW);
            PCWrite   = 1'b1;
            retire    = 1'b1;
            state_nx  = S_FETCH;
         end
         S_TRAP: begin
            illegal = 1'b1;
         end
         default: begin
            state_nx = S_TRAP;
         end
      endcase

      // Reset must withdraw an outstanding request immediately, not at the next edge.
      if (rst) begin
         mem_req  = 1'b0;
         mem_we   = 1'b0;
         AdrSrc   = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         retire   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose  : self-checking bench for multicycle_ctrl using a per-instruction cycle-plan model.
// Latency  : expectations derived from instruction class and memory wait counts.
// Backpress: mem_ready is driven per cycle; outputs sampled 1 time unit after the falling edge.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        EQ;
   logic        mem_ready;

   logic        mem_req, mem_we, AdrSrc, IRWrite, PCWrite, PCSrc;
   logic [1:0]  ALUctrl, Immsrc;
   logic        ALUsrc, RegWrite, ResultSrc, illegal;
   logic [31:0] retired;

   logic        mem_req4, mem_we4, AdrSrc4, IRWrite4, PCWrite4, PCSrc4;
   logic [1:0]  ALUctrl4, Immsrc4;
   logic        ALUsrc4, RegWrite4, ResultSrc4, illegal4;
   logic [3:0]  retired4;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] cnt;   // model count of retired instructions

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .EQ(EQ), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCSrc(PCSrc), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .Immsrc(Immsrc), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .illegal(illegal), .retired(retired)
   );

   multicycle_ctrl #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .EQ(EQ), .mem_ready(mem_ready),
      .mem_req(mem_req4), .mem_we(mem_we4), .AdrSrc(AdrSrc4), .IRWrite(IRWrite4), .PCWrite(PCWrite4),
      .PCSrc(PCSrc4), .ALUctrl(ALUctrl4), .ALUsrc(ALUsrc4), .Immsrc(Immsrc4), .RegWrite(RegWrite4),
      .ResultSrc(ResultSrc4), .illegal(illegal4), .retired(retired4)
   );

   typedef struct packed {
      logic       mem_req, mem_we, AdrSrc, IRWrite, PCWrite, PCSrc;
      logic [1:0] ALUctrl;
      logic       ALUsrc;
      logic [1:0] Immsrc;
      logic       RegWrite, ResultSrc, illegal;
   } outs_t;

   localparam int ADDI = 0, BNE = 1, LW = 2, SW = 3;
   localparam logic [2:0] PH_F = 3'd0, PH_D = 3'd1, PH_E = 3'd2, PH_M = 3'd3, PH_W = 3'd4;

   typedef struct packed {
      logic [2:0] ph;
      logic       rdy;
   } step_t;

   function automatic outs_t obs();
      outs_t o;
      o = '{mem_req, mem_we, AdrSrc, IRWrite, PCWrite, PCSrc, ALUctrl, ALUsrc, Immsrc,
            RegWrite, ResultSrc, illegal};
      return o;
   endfunction

   function automatic logic [6:0] op_of(input int k);
      case (k)
         ADDI:    return 7'b0010011;
         BNE:     return 7'b1100011;
         LW:      return 7'b0000011;
         default: return 7'b0100011;
      endcase
   endfunction

   function automatic logic [2:0] f3_of(input int k);
      return (k == ADDI) ? 3'b000 : (k == BNE) ? 3'b001 : 3'b010;
   endfunction

   // Expected controls for one cycle, straight from the per-state output table.
   function automatic outs_t model(input int k, input bit eq, input step_t s);
      outs_t e;
      e = '0;
      case (s.ph)
         PH_F: begin
            e.mem_req = 1'b1;
            e.IRWrite = s.rdy;
         end
         PH_E: begin
            if (k == BNE) begin
               e.Immsrc  = 2'b01;
               e.ALUctrl = 2'b01;
               e.PCWrite = 1'b1;
               e.PCSrc   = ~eq;
            end else begin
               e.ALUsrc = 1'b1;
               e.Immsrc = (k == SW) ? 2'b10 : 2'b00;
            end
         end
         PH_M: begin
            e.mem_req = 1'b1;
            e.AdrSrc  = 1'b1;
            e.mem_we  = (k == SW);
            e.PCWrite = (k == SW) && s.rdy;
         end
         PH_W: begin
            e.RegWrite  = 1'b1;
            e.ResultSrc = (k == LW);
            e.PCWrite   = 1'b1;
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   // Plans one instruction as a list of cycles, then drives and checks each cycle.
   // stop >= 0 truncates the plan after that many cycles.
   task automatic run_instr(input int k, input bit eq, input int fwait, input int mwait,
                            input int stop, input string tag);
      step_t q[$];
      outs_t e, o;
      logic [3:0] c4;
      for (int i = 0; i < fwait; i++) q.push_back('{PH_F, 1'b0});
      q.push_back('{PH_F, 1'b1});
      q.push_back('{PH_D, 1'b0});
      q.push_back('{PH_E, 1'b0});
      if (k == LW || k == SW) begin
         for (int i = 0; i < mwait; i++) q.push_back('{PH_M, 1'b0});
         q.push_back('{PH_M, 1'b1});
      end
      if (k == LW || k == ADDI) q.push_back('{PH_W, 1'b0});
      for (int i = 0; i < q.size(); i++) begin
         if (stop >= 0 && i >= stop) break;
         @(negedge clk);
         if (q[i].ph == PH_F) begin
            opcode = 7'($urandom);
            funct3 = 3'($urandom);
         end else begin
            opcode = op_of(k);
            funct3 = f3_of(k);
         end
         mem_ready = (q[i].ph == PH_F || q[i].ph == PH_M) ? q[i].rdy : 1'($urandom);
         EQ        = (q[i].ph == PH_E) ? eq : 1'($urandom);
         #1;
         e = model(k, eq, q[i]);
         o = obs();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL %s cycle%0d ctrl: got %b want %b", tag, i, o, e);
         end
         c4 = cnt[3:0];
         n_cmp++;
         if (retired !== cnt || retired4 !== c4) begin
            n_err++;
            $display("FAIL %s cycle%0d retired: got %0d/%0d want %0d/%0d", tag, i, retired, retired4, cnt, c4);
         end
         if (e.PCWrite) cnt++;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
   endtask

   task automatic test_reset();
      outs_t e;
      #1;
      n_cmp++;
      if (obs() !== outs_t'('0) || retired !== 32'd0) begin
         n_err++;
         $display("FAIL reset_hold: got %b/%0d want %b/0", obs(), retired, outs_t'('0));
      end
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      #1;
      e = '0;
      e.mem_req = 1'b1;
      n_cmp++;
      if (obs() !== e || retired !== 32'd0 || retired4 !== 4'd0) begin
         n_err++;
         $display("FAIL reset_release: got %b/%0d want %b/0", obs(), retired, e);
      end
   endtask

   task automatic test_addi();
      run_instr(ADDI, 1'b0, 0, 0, -1, "addi");
   endtask

   task automatic test_bne();
      run_instr(BNE, 1'b0, 0, 0, -1, "bne_taken");
      run_instr(BNE, 1'b1, 0, 0, -1, "bne_not_taken");
   endtask

   task automatic test_lw_wait();
      run_instr(LW, 1'b0, 0, 2, -1, "lw_wait");
   endtask

   task automatic test_sw_fetch_wait();
      run_instr(SW, 1'b0, 3, 0, -1, "sw_fetch_wait");
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++)
         run_instr($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), -1, "random");
   endtask

   // Drives FETCH + DECODE with the given encoding, then expects a sticky trap.
   task automatic test_illegal_enc(input logic [6:0] op, input logic [2:0] f3, input int hold,
                                   input string tag);
      outs_t e;
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      @(negedge clk);
      opcode = op;
      funct3 = f3;
      mem_ready = 1'($urandom);
      #1;
      n_cmp++;
      if (obs() !== outs_t'('0)) begin
         n_err++;
         $display("FAIL %s decode: got %b want %b", tag, obs(), outs_t'('0));
      end
      e = '0;
      e.illegal = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         mem_ready = 1'($urandom);
         opcode = 7'($urandom);
         funct3 = 3'($urandom);
         EQ = 1'($urandom);
         #1;
         n_cmp++;
         if (obs() !== e || retired !== cnt) begin
            n_err++;
            $display("FAIL %s trap%0d: got %b/%0d want %b/%0d", tag, i, obs(), retired, e, cnt);
         end
      end
      pulse_reset();
      #1;
      e = '0;
      e.mem_req = 1'b1;
      n_cmp++;
      if (obs() !== e || retired !== 32'd0) begin
         n_err++;
         $display("FAIL %s after_reset: got %b/%0d want %b/0", tag, obs(), retired, e);
      end
   endtask

   task automatic test_illegal();
      test_illegal_enc(7'b0110011, 3'b000, 20, "rtype_trap");
   endtask

   task automatic test_x_opcode();
      test_illegal_enc(7'bxxxxxxx, 3'b010, 3, "x_opcode_trap");
   endtask

   task automatic test_reset_mid_mem();
      outs_t e;
      run_instr(LW, 1'b0, 0, 5, 5, "lw_pre_reset");
      @(negedge clk);
      mem_ready = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0 || obs() !== outs_t'('0)) begin
         n_err++;
         $display("FAIL reset_mid_mem: got %b want %b", obs(), outs_t'('0));
      end
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      #1;
      e = '0;
      e.mem_req = 1'b1;
      n_cmp++;
      if (obs() !== e || retired !== 32'd0 || retired4 !== 4'd0) begin
         n_err++;
         $display("FAIL reset_mid_mem_release: got %b/%0d want %b/0", obs(), retired, e);
      end
   endtask

   task automatic test_wrap();
      pulse_reset();
      for (int n = 0; n < 16; n++)
         run_instr(ADDI, 1'b0, $urandom_range(0, 2), 0, -1, "wrap");
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if (retired4 !== 4'd0 || retired !== 32'd16) begin
         n_err++;
         $display("FAIL wrap: got %0d/%0d want 0/16", retired4, retired);
      end
   endtask

   initial begin
      rst = 1'b1;
      opcode = '0;
      funct3 = '0;
      EQ = 1'b0;
      mem_ready = 1'b0;
      cnt = 0;
      test_reset();
      test_addi();
      test_bne();
      test_lw_wait();
      test_sw_fetch_wait();
      test_random();
      test_illegal();
      test_x_opcode();
      test_reset_mid_mem();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
